// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider arbiter slice.
//   - state encoding of the arbiter FSM
//   - default operand width and requester count
//   - operand packing: requester i occupies bits [i*W +: W] of a packed bus
package div_pkg;

  localparam int unsigned DEFAULT_W    = 4;
  localparam int unsigned DEFAULT_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // LSB position of requester idx's lane in a packed NREQ*width operand bus.
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   eligible : requesters that may be granted this cycle
//   last_gnt : index of the most recently served requester
//   grant_c  : one-hot grant (all zero when nothing is eligible)
//   index_c  : binary index of the granted requester
// The search starts at (last_gnt + 1) mod NREQ and wraps.
module rr_pick
  import div_pkg::*;
#(
  parameter int unsigned NREQ = DEFAULT_NREQ,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  last_gnt,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  index_c
);

  logic [IDW-1:0] pos;
  logic           found;

  // First eligible requester after last_gnt, in wrap-around order.
  always_comb begin
    grant_c = '0;
    index_c = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = IDW'((32'(last_gnt) + k) % NREQ);
      if (!found && eligible[pos]) begin
        found        = 1'b1;
        grant_c[pos] = 1'b1;
        index_c      = pos;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one integer divider among NREQ requesters.
// A pending request is picked round-robin, its operands are latched, the
// divider is started with a one-cycle div_go, and on div_done the result is
// returned to the winner with a one-cycle one-hot rsp_valid pulse.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req, req_dividend,
//   req_divisor, req_n          per-requester request level and packed operands
//   rsp_valid                   one-hot response pulse
//   rsp_quotient/remainder/error shared response data, valid with rsp_valid
//   busy, cur_id                arbiter status and requester being served
//   div_go, div_dividend,
//   div_divisor, div_n          registered command to the divider
//   div_done, div_quotient,
//   div_remainder, div_error    divider result
//
// Build option: DIV_ARB_ZERO_BYPASS_EN answers zero-divisor requests directly
// (error set, zero quotient/remainder) without starting the divider.
module div_arbiter
  import div_pkg::*;
#(
  parameter int unsigned NREQ = DEFAULT_NREQ,
  parameter int unsigned W    = DEFAULT_W,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  input  logic [NREQ-1:0]   req_n,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_quotient,
  output logic [W-1:0]      rsp_remainder,
  output logic              rsp_error,
  output logic              busy,
  output logic [IDW-1:0]    cur_id,
  output logic              div_go,
  output logic [W-1:0]      div_dividend,
  output logic [W-1:0]      div_divisor,
  output logic              div_n,
  input  logic              div_done,
  input  logic [W-1:0]      div_quotient,
  input  logic [W-1:0]      div_remainder,
  input  logic              div_error
);

  localparam logic [IDW-1:0] LAST_GNT_RST = IDW'(NREQ - 1);

  state_t          state;
  logic [IDW-1:0]  last_gnt;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] gnt_oh;

  logic [NREQ-1:0] eligible_c;
  logic [NREQ-1:0] pick_grant_c;
  logic [IDW-1:0]  pick_idx_c;
  logic [W-1:0]    dvd_lane [NREQ];
  logic [W-1:0]    dvs_lane [NREQ];
  logic [W-1:0]    pick_dvd_c;
  logic [W-1:0]    pick_dvs_c;
  logic            pick_n_c;

  // Unpack the per-requester operand lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign dvd_lane[i] = req_dividend[lane_lsb(i, W) +: W];
    assign dvs_lane[i] = req_divisor[lane_lsb(i, W) +: W];
  end

  // The requester just served is hidden for one IDLE cycle while its req is
  // still high from the handshake.
  assign eligible_c = req & ~mask;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .eligible (eligible_c),
    .last_gnt (last_gnt),
    .grant_c  (pick_grant_c),
    .index_c  (pick_idx_c)
  );

  assign pick_dvd_c = dvd_lane[pick_idx_c];
  assign pick_dvs_c = dvs_lane[pick_idx_c];
  assign pick_n_c   = req_n[pick_idx_c];

  // Arbiter FSM; every output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      cur_id        <= '0;
      gnt_oh        <= '0;
      last_gnt      <= LAST_GNT_RST;
      mask          <= '0;
      div_go        <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_n         <= 1'b0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_error     <= 1'b0;
    end else begin
      div_go    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          mask <= '0;
          if (|eligible_c) begin
            cur_id       <= pick_idx_c;
            gnt_oh       <= pick_grant_c;
            div_dividend <= pick_dvd_c;
            div_divisor  <= pick_dvs_c;
            div_n        <= pick_n_c;
            busy         <= 1'b1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            if (pick_dvs_c == '0) begin
              state         <= ST_RESP;
              rsp_valid     <= pick_grant_c;
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
              rsp_error     <= 1'b1;
            end else begin
              state  <= ST_ISSUE;
              div_go <= 1'b1;
            end
`else
            state  <= ST_ISSUE;
            div_go <= 1'b1;
`endif
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_error     <= div_error;
            rsp_valid     <= gnt_oh;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_gnt <= cur_id;
          mask     <= gnt_oh;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: self-checking bench for div_arbiter with a behavioural
// divider and requester agents. Honours DIV_ARB_ZERO_BYPASS_EN.
module tb_div_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic [NREQ-1:0]   req_n;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_quotient;
  logic [W-1:0]      rsp_remainder;
  logic              rsp_error;
  logic              busy;
  logic [IDW-1:0]    cur_id;
  logic              div_go;
  logic [W-1:0]      div_dividend;
  logic [W-1:0]      div_divisor;
  logic              div_n;
  logic              div_done;
  logic [W-1:0]      div_quotient;
  logic [W-1:0]      div_remainder;
  logic              div_error;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_n         (req_n),
    .rsp_valid     (rsp_valid),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_error     (rsp_error),
    .busy          (busy),
    .cur_id        (cur_id),
    .div_go        (div_go),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_n         (div_n),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_error     (div_error)
  );

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       n;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       err;
    int         lat;
  } vec_t;

  int tests, fails, cyc;
  int ag_st [NREQ];            // 0 idle, 1 requesting, 3/2 response seen (hold req one more cycle)
  logic [W-1:0] o_a [NREQ];
  logic [W-1:0] o_b [NREQ];
  logic         o_n [NREQ];
  bit auto_en;
  int rate;
  int last_served, last_rsp_cyc;
  bit dbusy;
  int dcnt;
  logic [W-1:0] la, lb;
  int lat_fix, lat_min, lat_max;
  int go_cnt, rsp_cnt;
  bit go_prev;
  int served_q [$];
  logic [NREQ-1:0] prev_req;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Round-robin reference: first pending requester after 'last', wrapping.
  function automatic int rr_expect(input logic [NREQ-1:0] pend, input int last);
    int p;
    for (int k = 1; k <= int'(NREQ); k++) begin
      p = (last + k) % int'(NREQ);
      if (pend[p[IDW-1:0]]) return p;
    end
    return -1;
  endfunction

  // Expected {err, q, r} for a request with operands a / b.
  function automatic logic [2*W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
      return {1'b1, {W{1'b0}}, {W{1'b0}}};
`else
      return {1'b1, {W{1'b1}}, a};
`endif
    end
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({rsp_valid, rsp_quotient, rsp_remainder, rsp_error, busy, cur_id,
                div_go, div_dividend, div_divisor, div_n});
  endfunction

  function automatic bit all_idle();
    bit ok;
    ok = (busy == 1'b0);
    for (int i = 0; i < int'(NREQ); i++) if (ag_st[i] != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic n);
    o_a[i] = a;
    o_b[i] = b;
    o_n[i] = n;
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_n[i] = n;
    req[i]   = 1'b1;
    ag_st[i] = 1;
  endtask

  // One clock: divider model, monitors/scoreboard, requester agents.
  task automatic step();
    logic [NREQ-1:0] pend;
    logic [2*W:0]    ex;
    int  e, id;
    bit  done_was;
    prev_req = req;
    @(posedge clk);
    #1;
    cyc++;
    done_was = div_done;
    div_done = 1'b0;
    if (!rst) begin
      dbusy        = 1'b0;
      go_prev      = 1'b0;
      last_served  = int'(NREQ) - 1;
      last_rsp_cyc = -10;
    end else begin
      if (done_was) chk("rsp_latency", 32'(rsp_valid != '0), 32'd1);
      if (dbusy) begin
        chk("op_hold", 32'({div_dividend, div_divisor}), 32'({la, lb}));
        dcnt--;
        if (dcnt == 0) begin
          dbusy         = 1'b0;
          div_done      = 1'b1;
          div_quotient  = (lb == '0) ? '1 : W'(la / lb);
          div_remainder = (lb == '0) ? la : W'(la % lb);
          div_error     = (lb == '0);
        end
      end
      if (div_go) begin
        chk("go_single", 32'(go_prev), 32'd0);
        go_cnt++;
        pend = prev_req;
        if (cyc - 1 == last_rsp_cyc + 1) pend[last_served[IDW-1:0]] = 1'b0;
        e = rr_expect(pend, last_served);
        chk("grant_id", 32'(cur_id), 32'(e));
        if (e >= 0)
          chk("grant_ops", 32'({div_n, div_dividend, div_divisor}), 32'({o_n[e], o_a[e], o_b[e]}));
        la    = div_dividend;
        lb    = div_divisor;
        dbusy = 1'b1;
        dcnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(lat_max, lat_min));
      end
      go_prev = div_go;
      if (rsp_valid != '0) begin
        id = 0;
        for (int k = 0; k < int'(NREQ); k++) if (rsp_valid[k]) id = k;
        chk("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
        chk("rsp_id", 32'(cur_id), 32'(id));
        chk("rsp_pending", 32'(ag_st[id]), 32'd1);
        ex = ref_result(o_a[id], o_b[id]);
        chk("rsp_data", 32'({rsp_error, rsp_quotient, rsp_remainder}), 32'(ex));
        rsp_cnt++;
        served_q.push_back(id);
        last_served  = id;
        last_rsp_cyc = cyc;
        ag_st[id]    = 3;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        case (ag_st[i])
          3: ag_st[i] = 2;
          2: begin req[i] = 1'b0; ag_st[i] = 0; end
          0: if (auto_en && int'($urandom_range(99, 0)) < rate)
               raise(i, W'($urandom), W'($urandom_range((1 << W) - 1, 1)), 1'($urandom));
          default: ;
        endcase
      end
    end
  endtask

  task automatic wait_rsp(input int maxc);
    int k;
    k = 0;
    while (rsp_valid == '0 && k < maxc) begin
      step();
      k++;
    end
    chk("rsp_timeout", 32'(rsp_valid != '0), 32'd1);
  endtask

  task automatic drain(input int maxc);
    int k;
    bit idle;
    auto_en = 1'b0;
    k = 0;
    idle = all_idle();
    while (!idle && k < maxc) begin
      step();
      k++;
      idle = all_idle();
    end
    chk("drain", 32'(idle), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tv [8];
    int g0, r0, k;
    bit zero_byp;
    logic [NREQ-1:0] oh;

    tests = 0; fails = 0; cyc = 0;
    rst = 1'b0;
    req = '0; req_dividend = '0; req_divisor = '0; req_n = '0;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0; div_error = 1'b0;
    auto_en = 1'b0; rate = 0;
    lat_fix = 5; lat_min = 1; lat_max = 6;
    go_cnt = 0; rsp_cnt = 0; go_prev = 1'b0; dbusy = 1'b0; dcnt = 0;
    la = '0; lb = '0;
    last_served = int'(NREQ) - 1; last_rsp_cyc = -10;
    for (int i = 0; i < int'(NREQ); i++) begin
      ag_st[i] = 0; o_a[i] = '0; o_b[i] = '0; o_n[i] = 1'b0;
    end

    tv[0] = '{0, 4'd13, 4'd4,  1'b0, 4'd3,  4'd1, 1'b0, 5};
    tv[1] = '{1, 4'd15, 4'd2,  1'b1, 4'd7,  4'd1, 1'b0, 1};
    tv[2] = '{3, 4'd7,  4'd7,  1'b0, 4'd1,  4'd0, 1'b0, 3};
    tv[3] = '{2, 4'd0,  4'd5,  1'b1, 4'd0,  4'd0, 1'b0, 2};
    tv[4] = '{1, 4'd14, 4'd3,  1'b0, 4'd4,  4'd2, 1'b0, 6};
    tv[5] = '{3, 4'd11, 4'd4,  1'b1, 4'd2,  4'd3, 1'b0, 4};
`ifdef DIV_ARB_ZERO_BYPASS_EN
    tv[6] = '{2, 4'd9,  4'd0,  1'b0, 4'd0,  4'd0, 1'b1, 4};
`else
    tv[6] = '{2, 4'd9,  4'd0,  1'b0, 4'd15, 4'd9, 1'b1, 4};
`endif
    tv[7] = '{0, 4'd15, 4'd1,  1'b0, 4'd15, 4'd0, 1'b0, 1};

    // Reset state.
    repeat (3) step();
    chk("reset_outputs", out_vec(), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Single-requester vectors.
    for (int v = 0; v < 8; v++) begin
      g0 = go_cnt;
      lat_fix = tv[v].lat;
      oh = NREQ'(1) << tv[v].id;
      raise(tv[v].id, tv[v].a, tv[v].b, tv[v].n);
      step();
      zero_byp = 1'b0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      zero_byp = (tv[v].b == '0);
`endif
      if (zero_byp) chk($sformatf("vec%0d_bypass_latency", v), 32'(rsp_valid), 32'(oh));
      else          chk($sformatf("vec%0d_issue_latency", v), 32'(div_go), 32'd1);
      wait_rsp(40);
      chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'(oh));
      chk($sformatf("vec%0d_q", v), 32'(rsp_quotient), 32'(tv[v].q));
      chk($sformatf("vec%0d_r", v), 32'(rsp_remainder), 32'(tv[v].r));
      chk($sformatf("vec%0d_err", v), 32'(rsp_error), 32'(tv[v].err));
      step();
      chk($sformatf("vec%0d_busy_after_resp", v), 32'(busy), 32'd0);
      repeat (4) step();
      chk($sformatf("vec%0d_go_count", v), 32'(go_cnt - g0), zero_byp ? 32'd0 : 32'd1);
    end

    // Reset while waiting on the divider.
    served_q.delete();
    lat_fix = 12;
    raise(1, 4'd6, 4'd2, 1'b0);
    step();
    chk("rw_go", 32'(div_go), 32'd1);
    step();
    step();
    raise(0, 4'd5, 4'd1, 1'b0);
    raise(3, 4'd8, 4'd3, 1'b1);
    step();
    chk("rw_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    req[1] = 1'b0;
    ag_st[1] = 0;
    step();
    chk("rw_reset_out0", out_vec(), 32'd0);
    step();
    chk("rw_reset_out1", out_vec(), 32'd0);
    rst = 1'b1;
    lat_fix = 3;
    step();
    chk("rw_first_go", 32'(div_go), 32'd1);
    chk("rw_first_id", 32'(cur_id), 32'd0);
    drain(100);
    chk("rw_count", 32'(served_q.size()), 32'd2);
    if (served_q.size() >= 2) begin
      chk("rw_order0", 32'(served_q[0]), 32'd0);
      chk("rw_order1", 32'(served_q[1]), 32'd3);
    end

    // Operands must be held from grant even if the requester's bus changes.
    lat_fix = 6;
    raise(1, 4'd11, 4'd4, 1'b1);
    step();
    chk("stab_go", 32'(div_go), 32'd1);
    step();
    req_dividend[W +: W] = 4'd2;
    step();
    chk("stab_div_dividend", 32'(div_dividend), 32'd11);
    wait_rsp(20);
    chk("stab_q", 32'(rsp_quotient), 32'd2);
    chk("stab_r", 32'(rsp_remainder), 32'd3);
    drain(20);

    // Contention from reset: all four requesting continuously.
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    lat_fix = 0; lat_min = 1; lat_max = 4;
    served_q.delete();
    for (int i = 0; i < int'(NREQ); i++)
      raise(i, W'($urandom), W'($urandom_range((1 << W) - 1, 1)), 1'($urandom));
    auto_en = 1'b1;
    rate = 100;
    k = 0;
    while (served_q.size() < 8 && k < 300) begin
      step();
      k++;
    end
    chk("cont_jobs", 32'(served_q.size() >= 8), 32'd1);
    if (served_q.size() >= 8)
      for (int j = 0; j < 8; j++)
        chk($sformatf("cont_order%0d", j), 32'(served_q[j]), 32'(j % 4));
    drain(200);

    // Randomized traffic against the scoreboard.
    g0 = go_cnt;
    r0 = rsp_cnt;
    lat_min = 1; lat_max = 6;
    auto_en = 1'b1;
    rate = 25;
    repeat (3000) step();
    drain(300);
    chk("rand_go_vs_rsp", 32'(go_cnt - g0), 32'(rsp_cnt - r0));
    chk("rand_activity", 32'((rsp_cnt - r0) > 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Scheduler that shares one integer divider (control unit plus datapath) among NREQ independent requesters.
- Picks one pending request round-robin and latches its operands.
- Pulses the divider's go and waits for its done, then returns quotient, remainder and error to the winner with a one-cycle response pulse.
- Sits between client blocks and the single divider instance; the divider's go, done and result wires connect only here.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand/result width; must match the divider
- IDW, 2, width of cur_id; equals clog2(NREQ)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_dividend  in  NREQ*W  packed dividends; requester i occupies bits [i*W +: W]
- req_divisor  in  NREQ*W  packed divisors, same packing
- req_n  in  NREQ  per-requester n mode bit, passed to the divider
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse
- rsp_quotient  out  W  shared; valid only while rsp_valid is nonzero
- rsp_remainder  out  W  shared; valid only while rsp_valid is nonzero
- rsp_error  out  1  shared; valid only while rsp_valid is nonzero
- busy  out  1  high in any state other than IDLE
- cur_id  out  IDW  index of the requester being served
- div_go  out  1  start pulse to the divider
- div_dividend  out  W  registered operand to the divider
- div_divisor  out  W  registered operand to the divider
- div_n  out  1  registered mode bit to the divider
- div_done  in  1  divider completion
- div_quotient  in  W  divider result
- div_remainder  in  W  divider result
- div_error  in  1  divider error flag

Behaviour:
Reset:
- rst low forces IDLE asynchronously.
- All outputs and operand/result registers clear to 0; last_gnt = NREQ-1, so requester 0 has top priority first; mask clears.
- Reset mid-operation abandons the job with no response. The divider shares rst.

Request handshake:
- Requester raises req[i] and holds req[i] and its operands stable until it sees rsp_valid[i].
- It drops req[i] the following cycle. Operands are sampled once, at grant.

FSM (4 states):
- IDLE: eligible = req & ~mask.
  - If eligible is nonzero: pick the first set bit searching upward from (last_gnt+1) mod NREQ with wrap. Latch that requester's operands into div_dividend/div_divisor/div_n, set cur_id, go to ISSUE.
  - Otherwise stay in IDLE.
  - mask clears every IDLE cycle.
- ISSUE: div_go = 1 for exactly this cycle; go to WAIT.
- WAIT: div_go = 0; operands held stable.
  - On the first cycle div_done = 1: latch div_quotient, div_remainder and div_error into the rsp registers; go to RESP.
  - div_done is ignored in every other state.
  - No timeout; WAIT persists until done or reset.
- RESP: rsp_valid[cur_id] = 1 for this cycle only. last_gnt <= cur_id; mask <= onehot(cur_id); go to IDLE.

Masking:
- mask hides the just-served requester for the single IDLE cycle after RESP.
- This prevents re-serving its still-high req.

Latency:
- A request seen in IDLE at cycle t gives div_go at t+1.
- If div_done is first seen at cycle d, rsp_valid is high at d+1.
- Back-to-back minimum is 4 cycles plus the divider time.

Simultaneous requests:
- Exactly one grant per IDLE visit, in round-robin order.
- A request arriving during a busy period waits.
- Deasserting req before grant withdraws it; deasserting after grant is ignored.

Fairness:
- With all requesters active, each is served once per NREQ jobs.

Optional Feature:
- Macro: DIV_ARB_ZERO_BYPASS_EN.
- Defined: in IDLE, if the picked divisor is 0, skip ISSUE/WAIT and go directly to RESP.
  - Response: rsp_error = 1, rsp_quotient = 0, rsp_remainder = 0.
  - div_go is never pulsed; response comes at t+1.
- Undefined: zero divisors go to the divider like any other operand, and its div_error is returned.

Decomposition:
- Shared package/header div_pkg holds:
  - the state encoding localparams (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3)
  - default W = 4
  - the operand packing convention
- One sub-module: rr_pick. Combinational NREQ-wide round-robin picker; inputs eligible and last_gnt, outputs one-hot grant and index.

Test Plan:
- Single request: req = 0001, dividend 13, divisor 4, n = 0; divider model returns q = 3, r = 1 after 5 cycles. Expect div_go exactly 1 cycle, rsp_valid = 0001 with q = 3, r = 1, err = 0.
- Contention: req = 1111 held continuously from reset, each requester releasing its req after its own rsp_valid pulse and reasserting it. Expect grant order 0,1,2,3,0, one rsp pulse per job, cur_id matching.
- Mask check: req = 0100 only, held 1 cycle after rsp_valid. Expect no second div_go, and busy = 0 after RESP.
- Divide by zero: requester 2, dividend 9, divisor 0.
  - With DIV_ARB_ZERO_BYPASS_EN: rsp_valid = 0100 one cycle after grant, err = 1, q = 0, r = 0, no div_go.
  - Without the macro: div_go pulses and the model's error is returned.
- Reset in WAIT: rst low for 2 cycles. Expect all outputs 0 and state IDLE; after release, requester 0 has priority over pending requesters 0 and 3.
- Operand stability: change req_dividend[1] while in WAIT. Expect div_dividend unchanged and the response computed from the originally granted operands.
